// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq_pkg : opcode, FSM-state and flag-index definitions for alu_seq     |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_RSB   = 4'd2,
    OP_CLR   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_XNOR  = 4'd7,
    OP_LSL   = 4'd8,
    OP_LSR   = 4'd9,
    OP_ASR   = 4'd10,
    OP_ROR   = 4'd11,
    OP_MULU  = 4'd12,
    OP_DIVU  = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_RESP = 2'd2
  } alu_state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  localparam int FLG_Z   = 0;
  localparam int FLG_N   = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_CO  = 3;

  // Divide by zero is resolved in one cycle, so only a real divide iterates.
  function automatic logic needs_iter(input alu_op_e op, input logic b_zero);
    return (op == OP_MULU) || ((op == OP_DIVU) && !b_zero);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq_if : issue/response handshake between EX controller and alu_seq    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface alu_seq_if #(
  parameter int W = 8
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] rem;
  logic         co;
  logic         ovf;
  logic         n;
  logic         z;

  modport master (
    output flush, in_valid, op, a, b,
    input  in_ready, out_valid, result, rem, co, ovf, n, z
  );

  modport slave (
    input  flush, in_valid, op, a, b,
    output in_ready, out_valid, result, rem, co, ovf, n, z
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_muldiv_iter : bit-serial shift-add multiply / restoring divide engine  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         clear,
  input  wire logic         start,
  input  wire md_mode_e     mode,
  input  wire logic [W-1:0] a,
  input  wire logic [W-1:0] b,
  output logic              done,
  output logic [W-1:0]      hi,
  output logic [W-1:0]      lo
);
  localparam int CW = $clog2(W);

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_b;
  md_mode_e       r_mode;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;

  logic [W:0]     w_mul_sum;
  logic [W:0]     w_div_sh;
  logic [W:0]     w_div_diff;
  logic [2*W-1:0] w_next;

  // hi/lo expose the post-step accumulator so the caller can register the
  // final result on the same edge the last bit is processed.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    w_div_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
    w_div_diff = w_div_sh - {1'b0, r_b};
    if (r_mode == MD_DIV) begin
      if (!w_div_diff[W])
        w_next = {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};
      else
        w_next = {w_div_sh[W-1:0], r_acc[W-2:0], 1'b0};
    end else begin
      w_next = {w_mul_sum, r_acc[W-1:1]};
    end
  end

  assign done = r_busy && (r_cnt == '0);
  assign hi   = w_next[2*W-1:W];
  assign lo   = w_next[W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_b    <= '0;
      r_mode <= MD_MUL;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (clear) begin
      r_busy <= 1'b0;
    end else if (start) begin
      r_acc  <= {{W{1'b0}}, a};
      r_b    <= b;
      r_mode <= mode;
      r_cnt  <= CW'(W - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_next;
      if (r_cnt == '0)
        r_busy <= 1'b0;
      else
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq : registered EX-stage ALU with shifts and iterative MULU/DIVU      |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input wire logic clk,
  input wire logic reset,
  alu_seq_if.slave bus
);
  alu_op_e        w_op;
  logic           w_b_zero;
  logic [SHW-1:0] w_sh;
  logic           w_needs_iter;
  logic           w_accept;

  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic [W-1:0]   w_min;
  logic [W-1:0]   w_sub;
  logic [W:0]     w_lsl;
  logic [W:0]     w_lsr;
  logic [W:0]     w_asr;
  logic [2*W-1:0] w_ror;

  logic [W-1:0]   w_res;
  logic [W-1:0]   w_rem;
  logic           w_co;
  logic           w_ovf;
  logic [3:0]     w_flg;

  logic           w_md_done;
  logic [W-1:0]   w_md_hi;
  logic [W-1:0]   w_md_lo;
  logic [W-1:0]   w_it_rem;
  logic [3:0]     w_it_flg;

  alu_state_e     r_state;
  logic           r_is_div;
  logic           r_out_valid;
  logic [W-1:0]   r_result;
  logic [W-1:0]   r_rem;
  logic [3:0]     r_flg;

  assign w_op         = alu_op_e'(bus.op);
  assign w_b_zero     = (bus.b == '0);
  assign w_sh         = bus.b[SHW-1:0];
  assign w_needs_iter = needs_iter(w_op, w_b_zero);
  assign bus.in_ready = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;

  // Extra guard bit on each shift captures the last bit shifted out.
  always_comb begin
    w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    w_min  = (w_op == OP_RSB) ? bus.b : bus.a;
    w_sub  = (w_op == OP_RSB) ? bus.a : bus.b;
    w_diff = {1'b0, w_min} - {1'b0, w_sub};
    w_lsl  = {1'b0, bus.a} << w_sh;
    w_lsr  = {bus.a, 1'b0} >> w_sh;
    w_asr  = $unsigned($signed({bus.a, 1'b0}) >>> w_sh);
    w_ror  = {bus.a, bus.a} >> w_sh;

    w_res = '0;
    w_rem = '0;
    w_co  = 1'b0;
    w_ovf = 1'b0;
    case (w_op)
      OP_SUB, OP_RSB: begin
        w_res = w_diff[W-1:0];
        w_co  = ~w_diff[W];
        w_ovf = (w_min[W-1] != w_sub[W-1]) && (w_diff[W-1] != w_min[W-1]);
      end
      OP_CLR:  w_res = '0;
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_XNOR: w_res = ~(bus.a ^ bus.b);
      OP_LSL: begin
        w_res = w_lsl[W-1:0];
        w_co  = w_lsl[W];
      end
      OP_LSR: begin
        w_res = w_lsr[W:1];
        w_co  = w_lsr[0];
      end
      OP_ASR: begin
        w_res = w_asr[W:1];
        w_co  = w_asr[0];
      end
      OP_ROR: begin
        w_res = w_ror[W-1:0];
        w_co  = (w_sh != '0) && w_ror[W-1];
      end
      OP_MULU: w_res = '0;
      OP_DIVU: begin
        w_res = '1;
        w_rem = bus.a;
        w_ovf = 1'b1;
      end
      default: begin
        w_res = w_sum[W-1:0];
        w_co  = w_sum[W];
        w_ovf = (bus.a[W-1] == bus.b[W-1]) && (w_sum[W-1] != bus.a[W-1]);
      end
    endcase

    w_flg          = '0;
    w_flg[FLG_CO]  = w_co;
    w_flg[FLG_OVF] = w_ovf;
    w_flg[FLG_N]   = w_res[W-1];
    w_flg[FLG_Z]   = (w_res == '0);
  end

  always_comb begin
    w_it_rem       = r_is_div ? w_md_hi : '0;
    w_it_flg       = '0;
    w_it_flg[FLG_CO]  = !r_is_div && (w_md_hi != '0);
    w_it_flg[FLG_OVF] = !r_is_div && (w_md_hi != '0);
    w_it_flg[FLG_N]   = w_md_lo[W-1];
    w_it_flg[FLG_Z]   = (w_md_lo == '0);
  end

  alu_muldiv_iter #(
    .W (W)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .clear (bus.flush),
    .start (w_accept && w_needs_iter),
    .mode  ((w_op == OP_DIVU) ? MD_DIV : MD_MUL),
    .a     (bus.a),
    .b     (bus.b),
    .done  (w_md_done),
    .hi    (w_md_hi),
    .lo    (w_md_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_is_div    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rem       <= '0;
      r_flg       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE, ST_RESP: begin
            if (bus.in_valid) begin
              if (w_needs_iter) begin
                r_state  <= ST_ITER;
                r_is_div <= (w_op == OP_DIVU);
              end else begin
                r_state     <= ST_RESP;
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_rem       <= w_rem;
                r_flg       <= w_flg;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_ITER: begin
            if (w_md_done) begin
              r_state     <= ST_RESP;
              r_out_valid <= 1'b1;
              r_result    <= w_md_lo;
              r_rem       <= w_it_rem;
              r_flg       <= w_it_flg;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.rem       = r_rem;
  assign bus.co        = r_flg[FLG_CO];
  assign bus.ovf       = r_flg[FLG_OVF];
  assign bus.n         = r_flg[FLG_N];
  assign bus.z         = r_flg[FLG_Z];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_seq : directed vector table plus multi-cycle corner sequences       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_seq;
  localparam int W = 8;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] rem;
    logic [3:0] flg;   // {co, ovf, n, z}
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.co, bus.ovf, bus.n, bus.z};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
    drive(op, a, b);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic seen;

    vt.push_back(vec_t'{4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b0110, 1});
    vt.push_back(vec_t'{4'd1,  8'h05, 8'h07, 8'hFE, 8'h00, 4'b0010, 1});
    vt.push_back(vec_t'{4'd2,  8'h05, 8'h07, 8'h02, 8'h00, 4'b1000, 1});
    vt.push_back(vec_t'{4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001, 1});
    vt.push_back(vec_t'{4'd3,  8'hAA, 8'h55, 8'h00, 8'h00, 4'b0001, 1});
    vt.push_back(vec_t'{4'd4,  8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1});
    vt.push_back(vec_t'{4'd5,  8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b0010, 1});
    vt.push_back(vec_t'{4'd6,  8'hAA, 8'hFF, 8'h55, 8'h00, 4'b0000, 1});
    vt.push_back(vec_t'{4'd7,  8'hAA, 8'h55, 8'h00, 8'h00, 4'b0001, 1});
    vt.push_back(vec_t'{4'd8,  8'h81, 8'h01, 8'h02, 8'h00, 4'b1000, 1});
    vt.push_back(vec_t'{4'd8,  8'h81, 8'h08, 8'h81, 8'h00, 4'b0010, 1});
    vt.push_back(vec_t'{4'd9,  8'h8F, 8'h04, 8'h08, 8'h00, 4'b1000, 1});
    vt.push_back(vec_t'{4'd10, 8'hC0, 8'h07, 8'hFF, 8'h00, 4'b1010, 1});
    vt.push_back(vec_t'{4'd11, 8'h01, 8'h01, 8'h80, 8'h00, 4'b1010, 1});
    vt.push_back(vec_t'{4'd11, 8'h96, 8'h03, 8'hD2, 8'h00, 4'b1010, 1});
    vt.push_back(vec_t'{4'd12, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0010, 9});
    vt.push_back(vec_t'{4'd12, 8'h10, 8'h10, 8'h00, 8'h00, 4'b1101, 9});
    vt.push_back(vec_t'{4'd13, 8'h64, 8'h07, 8'h0E, 8'h02, 4'b0000, 9});
    vt.push_back(vec_t'{4'd13, 8'h55, 8'h00, 8'hFF, 8'h55, 4'b0110, 1});
    vt.push_back(vec_t'{4'd14, 8'h03, 8'h04, 8'h07, 8'h00, 4'b0000, 1});
    vt.push_back(vec_t'{4'd1,  8'h80, 8'h01, 8'h7F, 8'h00, 4'b1100, 1});
    vt.push_back(vec_t'{4'd12, 8'hFF, 8'hFF, 8'h01, 8'h00, 4'b1100, 9});
    vt.push_back(vec_t'{4'd13, 8'hFF, 8'h10, 8'h0F, 8'h0F, 4'b0000, 9});
    vt.push_back(vec_t'{4'd15, 8'hFF, 8'h02, 8'h01, 8'h00, 4'b1000, 1});

    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.a        = '0;
    bus.b        = '0;

    repeat (2) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result),    32'd0);
    chk("rst_rem",       32'(bus.rem),       32'd0);
    chk("rst_flags",     32'(flags()),       32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat),        32'(vt[i].lat));
      chk($sformatf("v%0d_result",  i), 32'(bus.result), 32'(vt[i].res));
      chk($sformatf("v%0d_rem",     i), 32'(bus.rem),    32'(vt[i].rem));
      chk($sformatf("v%0d_flags",   i), 32'(flags()),    32'(vt[i].flg));
    end

    // Back-to-back single-cycle ops with in_valid held high.
    drive(4'd0, 8'h01, 8'h01);
    step();
    chk("b2b0_valid",  32'(bus.out_valid), 32'd1);
    chk("b2b0_result", 32'(bus.result),    32'h02);
    drive(4'd6, 8'hF0, 8'h0F);
    step();
    chk("b2b1_valid",  32'(bus.out_valid), 32'd1);
    chk("b2b1_result", 32'(bus.result),    32'hFF);
    drive(4'd1, 8'h10, 8'h01);
    step();
    chk("b2b2_valid",  32'(bus.out_valid), 32'd1);
    chk("b2b2_result", 32'(bus.result),    32'h0F);
    bus.in_valid = 1'b0;
    step();
    chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);

    // New op presented while busy must be dropped, not queued.
    drive(4'd12, 8'h03, 8'h05);
    step();
    drive(4'd0, 8'h01, 8'h01);
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("busy%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
      step();
      lat++;
    end
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 30) begin
      step();
      lat++;
    end
    chk("busy_latency", 32'(lat),        32'd9);
    chk("busy_result",  32'(bus.result), 32'h0F);
    step();
    chk("busy_no_queue_valid",  32'(bus.out_valid), 32'd0);
    chk("busy_no_queue_result", 32'(bus.result),    32'h0F);

    // Flush in ITER cycle 4: no completion, previous result held.
    drive(4'd12, 8'h10, 8'h10);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) seen = 1'b1;
      step();
    end
    chk("flush_no_valid", 32'(seen),        32'd0);
    chk("flush_result",   32'(bus.result),  32'h0F);
    chk("flush_flags",    32'(flags()),     32'h0);

    // Asynchronous reset mid-ITER, applied away from the clock edge.
    drive(4'd12, 8'h0F, 8'h11);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    chk("areset_result",    32'(bus.result),    32'd0);
    chk("areset_rem",       32'(bus.rem),       32'd0);
    chk("areset_flags",     32'(flags()),       32'd0);
    chk("areset_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("areset_in_ready",  32'(bus.in_ready),  32'd1);
    issue(4'd0, 8'h7F, 8'h01, lat);
    chk("post_reset_latency", 32'(lat),        32'd1);
    chk("post_reset_result",  32'(bus.result), 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
